// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register file.
//   i2c_state_e  : target FSM state encoding (4 bits)
//   I2C_ACK/NACK : SDA level of the ninth (acknowledge) bit
//   BIT_CNT_W    : width of the per-byte bit counter (counts 0..8)
package i2c_pkg;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_ADDR      = 4'd1,
        ST_ADDR_ACK  = 4'd2,
        ST_PTR       = 4'd3,
        ST_PTR_ACK   = 4'd4,
        ST_WDATA     = 4'd5,
        ST_WDATA_ACK = 4'd6,
        ST_RDATA     = 4'd7,
        ST_RDATA_ACK = 4'd8
    } i2c_state_e;

    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    localparam int BIT_CNT_W = 4;

    // Counter value meaning "all 8 data bits seen, waiting for the ACK slot".
    localparam logic [BIT_CNT_W-1:0] BIT_ACK_SLOT = 4'd8;
    localparam logic [BIT_CNT_W-1:0] BIT_LAST     = 4'd7;

endpackage

// File: rtl/i2c_bus_sync.sv
// Bus front end: synchronises SCL/SDA into the clk domain, detects SCL edges
// and START/STOP conditions.
//   clk, reset       : system clock, async active-high reset
//   scl_i, sda_i     : raw bus lines
//   scl_rise/fall    : one-clk pulses on synchronised SCL edges
//   sda_s            : synchronised SDA
//   start_det        : SDA 1->0 while SCL high
//   stop_det         : SDA 0->1 while SCL high
module i2c_bus_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_rise,
    output logic scl_fall,
    output logic sda_s,
    output logic start_det,
    output logic stop_det
);

    logic [SYNC_STAGES-1:0] scl_sync_q, scl_sync_d;
    logic [SYNC_STAGES-1:0] sda_sync_q, sda_sync_d;
    logic                   scl_prev_q, scl_prev_d;
    logic                   sda_prev_q, sda_prev_d;
    logic                   scl_s;

    assign scl_s = scl_sync_q[SYNC_STAGES-1];
    assign sda_s = sda_sync_q[SYNC_STAGES-1];

    always_comb begin
        scl_sync_d = {scl_sync_q[SYNC_STAGES-2:0], scl_i};
        sda_sync_d = {sda_sync_q[SYNC_STAGES-2:0], sda_i};
        scl_prev_d = scl_s;
        sda_prev_d = sda_s;
    end

    // Reset to the idle-bus level so releasing reset never looks like an edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= scl_sync_d;
            sda_sync_q <= sda_sync_d;
            scl_prev_q <= scl_prev_d;
            sda_prev_q <= sda_prev_d;
        end
    end

    assign scl_rise  =  scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s &  scl_prev_q;
    // SCL must be high on both samples so an SCL edge coinciding with a data
    // change is never mistaken for a bus condition.
    assign start_det = scl_s & scl_prev_q &  sda_prev_q & ~sda_s;
    assign stop_det  = scl_s & scl_prev_q & ~sda_prev_q &  sda_s;

endmodule

// File: rtl/i2c_target_regfile.sv
// I2C target with a pointer-addressed register file and auto-increment.
//   clk, reset   : system clock (>= 8x SCL), async active-high reset
//   scl_i, sda_i : bus lines; sda_oe=1 pulls SDA low (open drain)
//   host_raddr/host_rdata : combinational host read port
//   wr_evt/wr_addr/wr_data: one-clk strobe per register written from the bus
//   busy         : set after an address-matched ACK, cleared on STOP/NACK/mismatch
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for START
// ST_ADDR      | shifting in address byte, compare on 8th bit
// ST_ADDR_ACK  | driving ACK for our address
// ST_PTR       | shifting in the pointer byte
// ST_PTR_ACK   | driving ACK for the pointer byte
// ST_WDATA     | shifting in a data byte, written on its 8th bit
// ST_WDATA_ACK | driving ACK for a data byte
// ST_RDATA     | shifting out regfile[ptr]
// ST_RDATA_ACK | SDA released, sampling master ACK/NACK
module i2c_target_regfile
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR    = 7'h50,
    parameter int         DEPTH_LOG2  = 4,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  scl_i,
    input  logic                  sda_i,
    output logic                  sda_oe,
    input  logic [DEPTH_LOG2-1:0] host_raddr,
    output logic [7:0]            host_rdata,
    output logic                  wr_evt,
    output logic [DEPTH_LOG2-1:0] wr_addr,
    output logic [7:0]            wr_data,
    output logic                  busy
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic scl_rise, scl_fall, sda_s, start_det, stop_det;

    i2c_bus_sync #(.SYNC_STAGES(SYNC_STAGES)) u_bus_sync (
        .clk       (clk),
        .reset     (reset),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .scl_rise  (scl_rise),
        .scl_fall  (scl_fall),
        .sda_s     (sda_s),
        .start_det (start_det),
        .stop_det  (stop_det)
    );

    i2c_state_e            state_q, state_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
    // Seven bits suffice: on receive the 8th bit comes straight from sda_s,
    // on transmit the MSB goes onto the bus at load time.
    logic [6:0]            shift_q, shift_d;
    logic [DEPTH_LOG2-1:0] ptr_q, ptr_d;
    logic                  sda_oe_q, sda_oe_d;
    logic                  busy_q, busy_d;
    logic                  wr_evt_q, wr_evt_d;
    logic [DEPTH_LOG2-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]            wr_data_q, wr_data_d;
    logic [7:0]            mem_q [DEPTH];
    logic [7:0]            mem_d [DEPTH];
    logic [7:0]            byte_in;
    logic [7:0]            rd_byte;

    assign byte_in = {shift_q, sda_s};
    assign rd_byte = mem_q[ptr_q];

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        ptr_d     = ptr_q;
        sda_oe_d  = sda_oe_q;
        busy_d    = busy_q;
        wr_evt_d  = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        mem_d     = mem_q;

        if (start_det) begin
            // Repeated START keeps ptr so write-pointer/read works.
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: ;
                ST_ADDR, ST_PTR, ST_WDATA: begin
                    if (scl_rise && bit_cnt_q != BIT_ACK_SLOT) begin
                        shift_d   = byte_in[6:0];
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        if (bit_cnt_q == BIT_LAST) begin
                            if (state_q == ST_ADDR) begin
                                if (byte_in[7:1] != DEV_ADDR) begin
                                    state_d   = ST_IDLE;
                                    bit_cnt_d = '0;
                                    busy_d    = 1'b0;
                                end
                            end else if (state_q == ST_PTR) begin
                                ptr_d = byte_in[DEPTH_LOG2-1:0];
                            end else begin
                                mem_d[ptr_q] = byte_in;
                                wr_evt_d     = 1'b1;
                                wr_addr_d    = ptr_q;
                                wr_data_d    = byte_in;
                                ptr_d        = ptr_q + DEPTH_LOG2'(1);
                            end
                        end
                    end else if (scl_fall && bit_cnt_q == BIT_ACK_SLOT) begin
                        sda_oe_d  = 1'b1;
                        bit_cnt_d = '0;
                        state_d   = (state_q == ST_ADDR) ? ST_ADDR_ACK :
                                    (state_q == ST_PTR)  ? ST_PTR_ACK  : ST_WDATA_ACK;
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        busy_d    = 1'b1;
                        bit_cnt_d = '0;
                        if (shift_q[0]) begin
                            state_d  = ST_RDATA;
                            shift_d  = rd_byte[6:0];
                            sda_oe_d = ~rd_byte[7];
                        end else begin
                            state_d  = ST_PTR;
                            sda_oe_d = 1'b0;
                        end
                    end
                end
                ST_PTR_ACK, ST_WDATA_ACK: begin
                    if (scl_fall) begin
                        state_d   = ST_WDATA;
                        bit_cnt_d = '0;
                        sda_oe_d  = 1'b0;
                    end
                end
                ST_RDATA: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == BIT_LAST) begin
                            state_d   = ST_RDATA_ACK;
                            bit_cnt_d = '0;
                            sda_oe_d  = 1'b0;
                            ptr_d     = ptr_q + DEPTH_LOG2'(1);
                        end else begin
                            sda_oe_d  = ~shift_q[6];
                            shift_d   = {shift_q[5:0], 1'b1};
                            bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        end
                    end
                end
                ST_RDATA_ACK: begin
                    if (scl_rise && bit_cnt_q != BIT_ACK_SLOT) begin
                        if (sda_s == I2C_ACK) begin
                            bit_cnt_d = BIT_ACK_SLOT;
                        end else begin
                            state_d   = ST_IDLE;
                            bit_cnt_d = '0;
                            busy_d    = 1'b0;
                        end
                    end else if (scl_fall && bit_cnt_q == BIT_ACK_SLOT) begin
                        state_d   = ST_RDATA;
                        bit_cnt_d = '0;
                        shift_d   = rd_byte[6:0];
                        sda_oe_d  = ~rd_byte[7];
                    end
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cnt_d = '0;
                    sda_oe_d  = 1'b0;
                    busy_d    = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            ptr_q     <= '0;
            sda_oe_q  <= 1'b0;
            busy_q    <= 1'b0;
            wr_evt_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            ptr_q     <= ptr_d;
            sda_oe_q  <= sda_oe_d;
            busy_q    <= busy_d;
            wr_evt_q  <= wr_evt_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            mem_q     <= mem_d;
        end
    end

    assign sda_oe     = sda_oe_q;
    assign busy       = busy_q;
    assign wr_evt     = wr_evt_q;
    assign wr_addr    = wr_addr_q;
    assign wr_data    = wr_data_q;
    assign host_rdata = mem_q[host_raddr];

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: bit-banged I2C master, register-file model
// held as a plain array plus pointer, directed cases then random transactions.
module tb_i2c_target_regfile;
    import i2c_pkg::*;

    localparam int Q = 6;   // clk cycles per quarter SCL period

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_bus;
    logic       sda_oe;
    logic [3:0] host_raddr = 4'd0;
    logic [7:0] host_rdata;
    logic       wr_evt;
    logic [3:0] wr_addr;
    logic [7:0] wr_data;
    logic       busy;

    assign sda_bus = sda_m & ~sda_oe;

    i2c_target_regfile #(.DEV_ADDR(7'h50), .DEPTH_LOG2(4), .SYNC_STAGES(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .scl_i      (scl_m),
        .sda_i      (sda_bus),
        .sda_oe     (sda_oe),
        .host_raddr (host_raddr),
        .host_rdata (host_rdata),
        .wr_evt     (wr_evt),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [7:0]  mem_m [16];
    int          ptr_m = 0;
    logic [7:0]  wbuf [4];
    logic [11:0] wr_log [256];
    int          wr_cnt = 0;
    int          oe_cnt = 0;

    always @(negedge clk) begin
        if (wr_evt) begin
            wr_log[wr_cnt % 256] = {wr_addr, wr_data};
            wr_cnt = wr_cnt + 1;
        end
        if (sda_oe) oe_cnt = oe_cnt + 1;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic bus_start;
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic bus_stop;
        sda_m = 1'b0; tick(Q);
        scl_m = 1'b1; tick(Q);
        sda_m = 1'b1; tick(Q);
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    tick(Q);
        scl_m = 1'b1; tick(2 * Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; tick(Q);
        scl_m = 1'b1; tick(Q);
        ack = sda_bus; tick(Q);
        scl_m = 1'b0; tick(Q);
    endtask

    task automatic read_byte(output logic [7:0] b, input logic ackv);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; tick(Q);
            scl_m = 1'b1; tick(Q);
            b[i] = sda_bus; tick(Q);
            scl_m = 1'b0; tick(Q);
        end
        send_bit(ackv);
    endtask

    task automatic check_host(input string tag);
        for (int a = 0; a < 16; a++) begin
            host_raddr = 4'(a);
            #1;
            chk($sformatf("%s host[%0d]", tag, a), host_rdata, mem_m[a]);
        end
    endtask

    task automatic do_write(input logic [7:0] pbyte, input int n, input string tag);
        logic ack;
        int   wc0;
        int   p0;
        wc0 = wr_cnt;
        bus_start;
        write_byte(8'hA0, ack);  chk({tag, " addr ack"}, ack, I2C_ACK);
        write_byte(pbyte, ack);  chk({tag, " ptr ack"}, ack, I2C_ACK);
        ptr_m = int'(pbyte) % 16;
        p0 = ptr_m;
        for (int k = 0; k < n; k++) begin
            write_byte(wbuf[k], ack);
            chk($sformatf("%s data%0d ack", tag, k), ack, I2C_ACK);
            mem_m[ptr_m] = wbuf[k];
            ptr_m = (ptr_m + 1) % 16;
        end
        chk({tag, " busy mid"}, busy, 1);
        bus_stop;
        chk({tag, " busy after stop"}, busy, 0);
        chk({tag, " wr_evt count"}, wr_cnt - wc0, n);
        for (int k = 0; k < n; k++)
            chk($sformatf("%s wr_evt%0d", tag, k), wr_log[(wc0 + k) % 256],
                {4'((p0 + k) % 16), wbuf[k]});
        chk({tag, " ptr"}, dut.ptr_q, ptr_m);
    endtask

    task automatic do_read(input logic set_ptr, input logic [7:0] pbyte, input int n,
                           input string tag);
        logic       ack;
        logic [7:0] b;
        bus_start;
        if (set_ptr) begin
            write_byte(8'hA0, ack); chk({tag, " waddr ack"}, ack, I2C_ACK);
            write_byte(pbyte, ack); chk({tag, " ptr ack"}, ack, I2C_ACK);
            ptr_m = int'(pbyte) % 16;
            bus_start;
        end
        write_byte(8'hA1, ack); chk({tag, " raddr ack"}, ack, I2C_ACK);
        chk({tag, " busy"}, busy, 1);
        for (int k = 0; k < n; k++) begin
            read_byte(b, (k == n - 1) ? I2C_NACK : I2C_ACK);
            chk($sformatf("%s byte%0d", tag, k), b, mem_m[ptr_m]);
            ptr_m = (ptr_m + 1) % 16;
        end
        chk({tag, " oe after nack"}, sda_oe, 0);
        chk({tag, " busy after nack"}, busy, 0);
        bus_stop;
        chk({tag, " ptr"}, dut.ptr_q, ptr_m);
    endtask

    task automatic do_mismatch(input logic [7:0] abyte, input string tag);
        logic ack;
        int   wc0;
        int   oe0;
        wc0 = wr_cnt;
        oe0 = oe_cnt;
        bus_start;
        write_byte(abyte, ack);
        chk({tag, " nack"}, ack, I2C_NACK);
        send_bit(1'b0);
        bus_stop;
        chk({tag, " oe never"}, oe_cnt - oe0, 0);
        chk({tag, " no wr_evt"}, wr_cnt - wc0, 0);
        chk({tag, " busy"}, busy, 0);
    endtask

    initial begin
        logic ack;
        int   wc0;
        int   oe0;
        logic [6:0] ra;

        for (int a = 0; a < 16; a++) mem_m[a] = 8'h00;
        tick(3);
        chk("reset sda_oe", sda_oe, 0);
        chk("reset busy", busy, 0);
        chk("reset wr_evt", wr_evt, 0);
        chk("reset wr_addr", wr_addr, 0);
        chk("reset wr_data", wr_data, 0);
        reset = 1'b0;
        tick(Q);
        check_host("reset");

        // pointer then two bytes
        wbuf[0] = 8'h5A; wbuf[1] = 8'hC3;
        do_write(8'h03, 2, "wr2");
        check_host("wr2");

        // combined write-pointer / read
        do_read(1'b1, 8'h03, 2, "rd2");

        // address mismatch, then normal START/0xA0
        oe0 = oe_cnt;
        wc0 = wr_cnt;
        bus_start;
        write_byte(8'h42, ack);
        chk("mis nack", ack, I2C_NACK);
        chk("mis oe never", oe_cnt - oe0, 0);
        bus_start;
        write_byte(8'hA0, ack);
        chk("mis then match ack", ack, I2C_ACK);
        bus_stop;
        chk("mis no wr_evt", wr_cnt - wc0, 0);

        // pointer wrap
        wbuf[0] = 8'h11; wbuf[1] = 8'h22;
        do_write(8'h0F, 2, "wrap");
        check_host("wrap");

        // STOP after 4 data bits
        wc0 = wr_cnt;
        bus_start;
        write_byte(8'hA0, ack); chk("midstop addr ack", ack, I2C_ACK);
        write_byte(8'h07, ack); chk("midstop ptr ack", ack, I2C_ACK);
        ptr_m = 7;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop;
        chk("midstop no wr_evt", wr_cnt - wc0, 0);
        chk("midstop state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("midstop oe", sda_oe, 0);
        chk("midstop busy", busy, 0);
        host_raddr = 4'd7; #1;
        chk("midstop reg7", host_rdata, mem_m[7]);

        // reset while the target drives a 0 (reg3 = 0x5A, MSB 0)
        bus_start;
        write_byte(8'hA0, ack); chk("rst addr ack", ack, I2C_ACK);
        write_byte(8'h03, ack); chk("rst ptr ack", ack, I2C_ACK);
        bus_start;
        write_byte(8'hA1, ack); chk("rst raddr ack", ack, I2C_ACK);
        chk("rst driving 0", sda_oe, 1);
        reset = 1'b1;
        #1;
        chk("rst async release", sda_oe, 0);
        scl_m = 1'b1; sda_m = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(Q);
        for (int a = 0; a < 16; a++) mem_m[a] = 8'h00;
        ptr_m = 0;
        check_host("after rst");
        chk("after rst ptr", dut.ptr_q, 0);
        chk("after rst busy", busy, 0);

        // random transactions
        for (int t = 0; t < 20; t++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    for (int k = 0; k < 4; k++) wbuf[k] = 8'($urandom_range(0, 255));
                    do_write(8'($urandom_range(0, 255)), int'($urandom_range(1, 3)),
                             $sformatf("rnd%0d wr", t));
                end
                2: begin
                    do_read(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                            int'($urandom_range(1, 3)), $sformatf("rnd%0d rd", t));
                end
                default: begin
                    ra = 7'($urandom_range(0, 127));
                    if (ra == 7'h50) ra = 7'h51;
                    do_mismatch({ra, 1'($urandom_range(0, 1))}, $sformatf("rnd%0d mis", t));
                end
            endcase
        end
        check_host("final");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
